ram_portb_arbiter: RTL and testbench

//  Shares port B of the dual-port program/data RAM among three requesters:
//  0 = CPU load/store, 1 = display fetch, 2 = I/O DMA.

---
 rtl/ram_portb_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_portb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_portb_arbiter.sv
// Round-robin arbiter sharing RAM port B among CPU, display and DMA.
// Issues one registered RAM command per cycle and routes read data back.
module ram_portb_arbiter #(
   parameter int ADDR_W   = 10,
   parameter int DATA_W   = 16,
   parameter int READ_LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            req,
   input  logic [2:0]            we,
   input  logic [3*ADDR_W-1:0]   addr,
   input  logic [3*DATA_W-1:0]   wdata,
   output logic [2:0]            gnt,
   output logic [2:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_data,
   output logic                  ram_we,
   input  logic [DATA_W-1:0]     ram_q
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } stateType;

   stateType state, stateNext;

   logic [2:0] elig;
   logic [1:0] ptr;
   logic [1:0] win;
   logic [1:0] nextPtr;
   logic       hasWin;
   logic [2:0] cand;

   logic                     issuedRead;
   logic [1:0]               issuedId;
   logic                     pipeBusy;
   logic [READ_LAT-1:0]      pipeV;
   logic [READ_LAT-1:0][1:0] pipeId;

   // Last cycle's winner is masked so a held req is not issued twice.
   always_comb begin
      elig   = req & ~gnt;
      hasWin = 1'b0;
      win    = ptr;
      cand   = 3'd0;
      for (int k = 0; k < 3; k++) begin
         cand = {1'b0, ptr} + 3'(k);
         if (cand >= 3'd3) cand = cand - 3'd3;
         if (!hasWin && elig[cand[1:0]]) begin
            hasWin = 1'b1;
            win    = cand[1:0];
         end
      end
      nextPtr = (win == 2'd2) ? 2'd0 : win + 2'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt      <= 3'b000;
         ram_addr <= '0;
         ram_data <= '0;
         ram_we   <= 1'b0;
         ptr      <= 2'd0;
      end else if (hasWin) begin
         gnt      <= 3'b001 << win;
         ram_addr <= addr[win*ADDR_W +: ADDR_W];
         ram_data <= wdata[win*DATA_W +: DATA_W];
         ram_we   <= we[win];
         ptr      <= nextPtr;
      end else begin
         gnt    <= 3'b000;
         ram_we <= 1'b0;
      end
   end

   // The registered gnt stage is the head of the read-latency pipe.
   always_comb begin
      issuedRead = (|gnt) & ~ram_we;
      issuedId   = 2'd0;
      if (gnt[1]) issuedId = 2'd1;
      if (gnt[2]) issuedId = 2'd2;
      pipeBusy   = issuedRead | (|pipeV);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipeV  <= '0;
         pipeId <= '0;
         rvalid <= 3'b000;
         rdata  <= '0;
      end else begin
         pipeV[0]  <= issuedRead;
         pipeId[0] <= issuedId;
         for (int k = 1; k < READ_LAT; k++) begin
            pipeV[k]  <= pipeV[k-1];
            pipeId[k] <= pipeId[k-1];
         end
         if (pipeV[READ_LAT-1]) begin
            rvalid <= 3'b001 << pipeId[READ_LAT-1];
            rdata  <= ram_q;
         end else begin
            rvalid <= 3'b000;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: begin
            if (|elig) stateNext = ISSUE;
         end
         ISSUE: begin
            if (|elig)         stateNext = ISSUE;
            else if (pipeBusy) stateNext = DRAIN;
            else               stateNext = IDLE;
         end
         DRAIN: begin
            if (|elig)          stateNext = ISSUE;
            else if (!pipeBusy) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// Directed bench for ram_portb_arbiter with synchronous RAM models
// at read latency 1 and 3.
module tb_ram_portb_arbiter;

   localparam int AW = 10;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]      req, we, gnt, rvalid;
   logic [3*AW-1:0] addr;
   logic [3*DW-1:0] wdata;
   logic [DW-1:0]   rdata, ramData, ramQ;
   logic [AW-1:0]   ramAddr;
   logic            ramWe;

   logic [2:0]      req3, we3, gnt3, rvalid3;
   logic [3*AW-1:0] addr3;
   logic [3*DW-1:0] wdata3;
   logic [DW-1:0]   rdata3, ramData3, ramQ3;
   logic [AW-1:0]   ramAddr3;
   logic            ramWe3;

   ram_portb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr),
      .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .ram_addr(ramAddr), .ram_data(ramData), .ram_we(ramWe),
      .ram_q(ramQ)
   );

   ram_portb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req(req3), .we(we3), .addr(addr3),
      .wdata(wdata3), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
      .ram_addr(ramAddr3), .ram_data(ramData3), .ram_we(ramWe3),
      .ram_q(ramQ3)
   );

   logic [DW-1:0] mem  [1024];
   logic [DW-1:0] mem3 [1024];
   logic          load;
   logic [AW-1:0] loadA;
   logic [DW-1:0] loadD;
   logic [DW-1:0] r1, r2;

   always @(posedge clk) begin
      if (load)       mem[loadA]   <= loadD;
      else if (ramWe) mem[ramAddr] <= ramData;
      ramQ <= mem[ramAddr];
   end

   always @(posedge clk) begin
      if (load)        mem3[loadA]    <= loadD;
      else if (ramWe3) mem3[ramAddr3] <= ramData3;
      r1    <= mem3[ramAddr3];
      r2    <= r1;
      ramQ3 <= r2;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      load  = 1'b1;
      loadA = a;
      loadD = d;
      @(negedge clk);
      load  = 1'b0;
   endtask

   task automatic setCmd(input int i, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
      we[i]             = w;
      addr[i*AW +: AW]  = a;
      wdata[i*DW +: DW] = d;
   endtask

   logic [2:0]  gExp  [6];
   logic [2:0]  rvExp [6];
   logic [15:0] dExp  [6];
   logic [2:0]  g5Exp [4];

   initial begin
      rst = 1'b0;
      req = '0; we = '0; addr = '0; wdata = '0;
      req3 = '0; we3 = '0; addr3 = '0; wdata3 = '0;
      load = 1'b0; loadA = '0; loadD = '0;
      gExp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      rvExp = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
      dExp  = '{16'h0, 16'h0, 16'hBEEF, 16'h1234, 16'hCAFE, 16'hBEEF};
      g5Exp = '{3'b001, 3'b000, 3'b001, 3'b000};

      @(negedge clk);
      preload(10'h005, 16'hBEEF);
      preload(10'h020, 16'hCAFE);
      preload(10'h040, 16'h1111);
      preload(10'h041, 16'h2222);
      check("rst gnt", 32'(gnt), 32'h0);
      check("rst rvalid", 32'(rvalid), 32'h0);
      check("rst rdata", 32'(rdata), 32'h0);
      check("rst ram_addr", 32'(ramAddr), 32'h0);
      check("rst ram_data", 32'(ramData), 32'h0);
      check("rst ram_we", 32'(ramWe), 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // single read
      setCmd(0, 1'b0, 10'h005, 16'h0);
      req = 3'b001;
      @(negedge clk);
      check("rd gnt", 32'(gnt), 32'h1);
      check("rd ram_addr", 32'(ramAddr), 32'h005);
      check("rd ram_we", 32'(ramWe), 32'h0);
      req = 3'b000;
      @(negedge clk);
      check("rd rvalid early", 32'(rvalid), 32'h0);
      @(negedge clk);
      check("rd rvalid", 32'(rvalid), 32'h1);
      check("rd rdata", 32'(rdata), 32'hBEEF);
      @(negedge clk);
      check("rd rvalid pulse", 32'(rvalid), 32'h0);

      // write then read back
      setCmd(0, 1'b1, 10'h010, 16'h1234);
      req = 3'b001;
      @(negedge clk);
      check("wr gnt", 32'(gnt), 32'h1);
      check("wr ram_we", 32'(ramWe), 32'h1);
      check("wr ram_data", 32'(ramData), 32'h1234);
      check("wr ram_addr", 32'(ramAddr), 32'h010);
      setCmd(0, 1'b0, 10'h010, 16'h0);
      @(negedge clk);
      check("wr gap gnt", 32'(gnt), 32'h0);
      check("wr gap we", 32'(ramWe), 32'h0);
      @(negedge clk);
      check("wr rd gnt", 32'(gnt), 32'h1);
      check("wr rd we", 32'(ramWe), 32'h0);
      check("wr rd addr", 32'(ramAddr), 32'h010);
      req = 3'b000;
      @(negedge clk);
      check("wr no rvalid", 32'(rvalid), 32'h0);
      @(negedge clk);
      check("wr rd rvalid", 32'(rvalid), 32'h1);
      check("wr rd rdata", 32'(rdata), 32'h1234);

      // reset in the middle of a read
      @(negedge clk);
      setCmd(0, 1'b0, 10'h020, 16'h0);
      req = 3'b001;
      @(negedge clk);
      check("mid gnt", 32'(gnt), 32'h1);
      req = 3'b000;
      rst = 1'b0;
      #1;
      check("mid rst gnt", 32'(gnt), 32'h0);
      check("mid rst ram_addr", 32'(ramAddr), 32'h0);
      check("mid rst ram_data", 32'(ramData), 32'h0);
      check("mid rst ram_we", 32'(ramWe), 32'h0);
      check("mid rst rvalid", 32'(rvalid), 32'h0);
      check("mid rst rdata", 32'(rdata), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("mid no rvalid", 32'(rvalid), 32'h0);
      end

      // all three requesters streaming reads
      setCmd(0, 1'b0, 10'h005, 16'h0);
      setCmd(1, 1'b0, 10'h010, 16'h0);
      setCmd(2, 1'b0, 10'h020, 16'h0);
      req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr gnt", 32'(gnt), 32'(gExp[k]));
         check("rr rvalid", 32'(rvalid), 32'(rvExp[k]));
         if (rvExp[k] != 3'b000)
            check("rr rdata", 32'(rdata), 32'(dExp[k]));
      end
      req = 3'b000;
      repeat (3) @(negedge clk);

      // lone requester held high: masking forces a gap
      setCmd(0, 1'b1, 10'h030, 16'h5555);
      req = 3'b001;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("hold gnt", 32'(gnt), 32'(g5Exp[k]));
         check("hold we", 32'(ramWe), 32'(g5Exp[k][0]));
      end
      req = 3'b000;
      @(negedge clk);
      check("hold idle", 32'(gnt), 32'h0);

      // read latency 3, back-to-back reads from 1 and 2
      addr3[1*AW +: AW] = 10'h040;
      addr3[2*AW +: AW] = 10'h041;
      we3  = 3'b000;
      req3 = 3'b110;
      @(negedge clk);
      check("l3 gnt1", 32'(gnt3), 32'h2);
      check("l3 state issue", 32'(dut3.state), 32'd1);
      req3 = 3'b100;
      @(negedge clk);
      check("l3 gnt2", 32'(gnt3), 32'h4);
      check("l3 state issue2", 32'(dut3.state), 32'd1);
      req3 = 3'b000;
      @(negedge clk);
      check("l3 gnt idle", 32'(gnt3), 32'h0);
      check("l3 state drain", 32'(dut3.state), 32'd2);
      @(negedge clk);
      check("l3 rvalid early", 32'(rvalid3), 32'h0);
      @(negedge clk);
      check("l3 rvalid1", 32'(rvalid3), 32'h2);
      check("l3 rdata1", 32'(rdata3), 32'h1111);
      @(negedge clk);
      check("l3 rvalid2", 32'(rvalid3), 32'h4);
      check("l3 rdata2", 32'(rdata3), 32'h2222);
      check("l3 state drain2", 32'(dut3.state), 32'd2);
      @(negedge clk);
      check("l3 rvalid end", 32'(rvalid3), 32'h0);
      check("l3 state idle", 32'(dut3.state), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
